// File: rtl/puf_challenge_driver.sv
// rtl/puf_challenge_driver.sv - arbiter PUF challenge initiator with repeated races and majority vote
module puf_challenge_driver #(
  parameter int N             = 128,
  parameter int SETTLE_CYCLES = 4,
  parameter int RACE_CYCLES   = 8,
  parameter int VOTES         = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         chal_valid,
  output logic         chal_ready,
  input  logic [N-1:0] chal_data,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_bit,
  output logic         resp_stable,
  output logic         busy,
  output logic [N-1:0] puf_sel,
  output logic         puf_in,
  output logic         puf_reset,
  input  logic         puf_out
);

  localparam int CW   = $clog2(VOTES + 1);
  localparam int TMAX = (SETTLE_CYCLES > RACE_CYCLES) ? SETTLE_CYCLES : RACE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] RACE_LAST   = TW'(RACE_CYCLES - 1);
  localparam logic [CW-1:0] VOTES_C     = CW'(VOTES);
  localparam logic [CW-1:0] HALF_C      = CW'(VOTES / 2);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RACE, S_SAMPLE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] vote_q, vote_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_bit_q, resp_bit_d;
  logic          resp_stable_q, resp_stable_d;
  logic          busy_q, busy_d;
  logic          puf_in_q, puf_in_d;
  logic          puf_reset_q, puf_reset_d;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    timer_d       = timer_q;
    vote_d        = vote_q;
    ones_d        = ones_q;
    resp_valid_d  = resp_valid_q;
    resp_bit_d    = resp_bit_q;
    resp_stable_d = resp_stable_q;
    sync1_d       = puf_out;
    sync2_d       = sync1_q;
    case (state_q)
      S_IDLE: begin
        if (chal_valid) begin
          sel_d   = chal_data;
          vote_d  = '0;
          ones_d  = '0;
          timer_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = S_RACE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RACE: begin
        if (timer_q == RACE_LAST) begin
          timer_d = '0;
          state_d = S_SAMPLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SAMPLE: begin
        ones_d  = ones_q + CW'(sync2_q);
        vote_d  = vote_q + CW'(1);
        timer_d = '0;
        state_d = (vote_d == VOTES_C) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        // First DONE cycle loads the verdict; the handshake is only honoured once it is visible.
        if (!resp_valid_q) begin
          resp_valid_d  = 1'b1;
          resp_bit_d    = (ones_q > HALF_C);
          resp_stable_d = (ones_q == '0) || (ones_q == VOTES_C);
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    puf_in_d    = (state_d == S_RACE) || (state_d == S_SAMPLE);
    puf_reset_d = !puf_in_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      timer_q       <= '0;
      vote_q        <= '0;
      ones_q        <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_bit_q    <= 1'b0;
      resp_stable_q <= 1'b0;
      busy_q        <= 1'b0;
      puf_in_q      <= 1'b0;
      puf_reset_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      timer_q       <= timer_d;
      vote_q        <= vote_d;
      ones_q        <= ones_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      resp_valid_q  <= resp_valid_d;
      resp_bit_q    <= resp_bit_d;
      resp_stable_q <= resp_stable_d;
      busy_q        <= busy_d;
      puf_in_q      <= puf_in_d;
      puf_reset_q   <= puf_reset_d;
    end
  end

  assign chal_ready  = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_bit    = resp_bit_q;
  assign resp_stable = resp_stable_q;
  assign busy        = busy_q;
  assign puf_sel     = sel_q;
  assign puf_in      = puf_in_q;
  assign puf_reset   = puf_reset_q;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// tb/tb_puf_challenge_driver.sv - directed vector bench for puf_challenge_driver
module tb_puf_challenge_driver;

  logic         clk = 1'b0;
  logic         reset;
  logic         chal_valid;
  logic         chal_ready;
  logic [127:0] chal_data;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_bit;
  logic         resp_stable;
  logic         busy;
  logic [127:0] puf_sel;
  logic         puf_in;
  logic         puf_reset;
  logic         puf_out = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  puf_challenge_driver dut (
    .clk(clk), .reset(reset),
    .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_data(chal_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_bit(resp_bit), .resp_stable(resp_stable), .busy(busy),
    .puf_sel(puf_sel), .puf_in(puf_in), .puf_reset(puf_reset), .puf_out(puf_out)
  );

  always #5 clk = ~clk;

  // PUF model: race k (first race = pattern bit 4) latches cur_pat, cleared by puf_reset.
  logic [4:0] cur_pat = 5'b0;
  int         rise_cnt = 0;
  int         base = 0;
  int         m_idx;
  bit         m_prev = 1'b0;
  assign m_idx = rise_cnt - base;

  always @(posedge clk) begin
    if (puf_reset) puf_out <= 1'b0;
    else if (puf_in && !m_prev) puf_out <= (m_idx >= 0 && m_idx < 5) ? cur_pat[4 - m_idx] : 1'b0;
    if (puf_in && !m_prev) rise_cnt <= rise_cnt + 1;
    m_prev <= puf_in;
  end

  typedef struct {
    logic [4:0]   pat;
    logic [127:0] data;
    logic         exp_bit;
    logic         exp_stable;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic run_body(input logic [127:0] data, input logic eb, input logic es, input int id);
    int rises = 0, bad_wave = 0, bad_sel = 0, both_high = 0;
    int reset_run = 0, high_len = 0, lat = -1;
    logic prev_in = 1'b0;
    for (int n = 0; n < 200 && lat < 0; n++) begin
      @(negedge clk);
      if (puf_sel !== data) bad_sel++;
      if (puf_in && puf_reset) both_high++;
      if (puf_in && !prev_in) begin
        rises++;
        if (reset_run != 4) bad_wave++;
      end
      if (!puf_in && prev_in && high_len != 9) bad_wave++;
      if (puf_in) begin
        high_len  = prev_in ? high_len + 1 : 1;
        reset_run = 0;
      end else begin
        reset_run = puf_reset ? reset_run + 1 : 0;
      end
      prev_in = puf_in;
      if (resp_valid) lat = n;
    end
    check($sformatf("latency[%0d]", id), 128'(lat), 128'(66));
    check($sformatf("resp_bit[%0d]", id), 128'(resp_bit), 128'(eb));
    check($sformatf("resp_stable[%0d]", id), 128'(resp_stable), 128'(es));
    check($sformatf("rises[%0d]", id), 128'(rises), 128'(5));
    check($sformatf("wave_shape[%0d]", id), 128'(bad_wave), 128'(0));
    check($sformatf("sel_held[%0d]", id), 128'(bad_sel), 128'(0));
    check($sformatf("in_reset_overlap[%0d]", id), 128'(both_high), 128'(0));
  endtask

  task automatic accept(input logic [4:0] pat, input logic [127:0] data, input int id);
    chal_data  = data;
    chal_valid = 1'b1;
    cur_pat    = pat;
    base       = rise_cnt;
    check($sformatf("chal_ready_idle[%0d]", id), 128'(chal_ready), 128'(1));
    @(posedge clk);
    #1 chal_valid = 1'b0;
  endtask

  task automatic consume(input int id);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check($sformatf("resp_dropped[%0d]", id), 128'(resp_valid), 128'(0));
  endtask

  task automatic run_chal(input vec_t v, input int id);
    accept(v.pat, v.data, id);
    run_body(v.data, v.exp_bit, v.exp_stable, id);
    consume(id);
  endtask

  initial begin
    logic [127:0] d1, d2;
    logic hb, hs;
    int changed, stray;
    vecs[0] = '{5'b11111, {16{8'hA5}}, 1'b1, 1'b1};
    vecs[1] = '{5'b10110, {4{32'hDEADBEEF}}, 1'b1, 1'b0};
    vecs[2] = '{5'b00101, {2{64'h0123456789ABCDEF}}, 1'b0, 1'b0};
    vecs[3] = '{5'b00000, {128{1'b1}}, 1'b0, 1'b1};
    vecs[4] = '{5'b01000, 128'h1, 1'b0, 1'b0};

    reset = 1'b0; chal_valid = 1'b0; chal_data = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_puf_reset", 128'(puf_reset), 128'(1));
    check("rst_puf_in", 128'(puf_in), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_chal_ready", 128'(chal_ready), 128'(1));
    check("post_rst_busy", 128'(busy), 128'(0));
    check("post_rst_resp_valid", 128'(resp_valid), 128'(0));
    check("post_rst_puf_sel", puf_sel, 128'(0));

    for (int i = 0; i < 5; i++) run_chal(vecs[i], i);

    // Back-pressure: response held while a new challenge waits.
    d1 = {8{16'h3C5A}};
    d2 = {8{16'h0FF0}};
    accept(5'b11100, d1, 10);
    run_body(d1, 1'b1, 1'b0, 10);
    hb = resp_bit; hs = resp_stable;
    chal_data = d2; chal_valid = 1'b1;
    changed = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_bit !== hb || resp_stable !== hs || chal_ready !== 1'b0) changed++;
    end
    check("bp_hold", 128'(changed), 128'(0));
    cur_pat = 5'b00011; base = rise_cnt;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("bp_not_accepted_sel", puf_sel, d1);
    check("bp_idle_busy", 128'(busy), 128'(0));
    check("bp_idle_ready", 128'(chal_ready), 128'(1));
    @(posedge clk);
    #1 chal_valid = 1'b0;
    run_body(d2, 1'b0, 1'b0, 11);
    consume(11);

    // Reset pulse during the third race.
    accept(5'b11111, d1, 20);
    repeat (31) @(negedge clk);
    check("mid_race_puf_in", 128'(puf_in), 128'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_puf_in", 128'(puf_in), 128'(0));
    check("mid_rst_puf_reset", 128'(puf_reset), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_puf_sel", puf_sel, 128'(0));
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("mid_rst_no_resp", 128'(stray), 128'(0));
    run_chal('{5'b11010, d2, 1'b1, 1'b0}, 21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
